// File: rtl/avg_sample_feeder_if.sv
// Upstream push port, averager sample/handshake port and status flags of the sample feeder.
// master = producer/averager side, slave = feeder.
interface avg_sample_feeder_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        empty;
  logic        drop;
  logic        modwait;
  logic        err;
  logic [15:0] sample_data;
  logic        data_ready;
  logic [9:0]  sent_count;
  logic        err_seen;
  logic        timeout;

  modport master (
    output wr_en, wr_data, modwait, err,
    input  full, empty, drop, sample_data, data_ready, sent_count, err_seen, timeout
  );

  modport slave (
    input  wr_en, wr_data, modwait, err,
    output full, empty, drop, sample_data, data_ready, sent_count, err_seen, timeout
  );
endinterface

// File: rtl/avg_sample_feeder.sv
// Buffers upstream 16-bit samples and presents them one at a time to the averager, paced by modwait.
// Optional ACK watchdog enabled by defining AVG_SAMPLE_FEEDER_TIMEOUT_EN.
module avg_sample_feeder #(
  parameter int DEPTH          = 8,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  avg_sample_feeder_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("avg_sample_feeder: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, ACK, BUSY} state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [HW-1:0]   hold_q, hold_d;
  logic [15:0]     sample_q, sample_d;
  logic            data_ready_q, data_ready_d;
  logic [9:0]      sent_q, sent_d;
  logic            err_seen_q, err_seen_d;
  logic            full_w, empty_w, push, pop;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign push    = bus.wr_en && !full_w;

  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.drop        = bus.wr_en && full_w;
  assign bus.sample_data = sample_q;
  assign bus.data_ready  = data_ready_q;
  assign bus.sent_count  = sent_q;
  assign bus.err_seen    = err_seen_q;

`ifdef AVG_SAMPLE_FEEDER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    sample_d   = sample_q;
    sent_d     = sent_q;
    pop        = 1'b0;
    err_seen_d = err_seen_q | (bus.err && (state_q inside {STROBE, ACK, BUSY}));
`ifdef AVG_SAMPLE_FEEDER_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        // Load on the way into LOAD so the data leads data_ready by one cycle.
        if (!empty_w && !bus.modwait) begin
          state_d  = LOAD;
          sample_d = mem_q[rd_ptr_q];
        end
      end
      LOAD: begin
        state_d = STROBE;
        hold_d  = '0;
`ifdef AVG_SAMPLE_FEEDER_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      STROBE: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = ACK;
        else                                hold_d  = hold_q + 1'b1;
      end
      ACK: begin
        if (bus.modwait) begin
          state_d = BUSY;
        end
`ifdef AVG_SAMPLE_FEEDER_TIMEOUT_EN
        // Give up without popping; the head sample is retried on the next pass.
        else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      BUSY: begin
        if (!bus.modwait) begin
          state_d = IDLE;
          pop     = 1'b1;
          sent_d  = sent_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    data_ready_d = (state_d == STROBE);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      sample_q     <= '0;
      data_ready_q <= 1'b0;
      sent_q       <= '0;
      err_seen_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      sample_q     <= sample_d;
      data_ready_q <= data_ready_d;
      sent_q       <= sent_d;
      err_seen_q   <= err_seen_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

`ifdef AVG_SAMPLE_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule
